// File: rtl/sprite_motion_ctrl_pkg.sv
// Shared geometry defaults and FSM encoding for the sprite motion controller.
package sprite_motion_ctrl_pkg;

   localparam int SCREEN_W_DEF   = 640;
   localparam int SCREEN_H_DEF   = 480;
   localparam int SPRITE_WID_DEF = 40;
   localparam int SPRITE_HGT_DEF = 40;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WAIT   = 3'd1,
      ST_CALC_X = 3'd2,
      ST_CALC_Y = 3'd3,
      ST_COMMIT = 3'd4
   } state_t;

endpackage

// File: rtl/sprite_axis_step.sv
// One-axis move with edge reflection; shared between X and Y by the controller.
module sprite_axis_step (
   input  logic [9:0] pos,
   input  logic       dir,
   input  logic [3:0] step,
   input  logic [9:0] lim,
   output logic [9:0] npos,
   output logic       ndir
);

   logic [10:0] sum;

   assign sum = {1'b0, pos} + {7'd0, step};

   // A zero step freezes the axis even when parked on a limit.
   always_comb begin
      npos = pos;
      ndir = dir;
      if (step != 4'd0) begin
         if (pos > lim) begin
            npos = lim;
            ndir = 1'b0;
         end else if (dir) begin
            if (sum >= {1'b0, lim}) begin
               npos = lim;
               ndir = 1'b0;
            end else begin
               npos = sum[9:0];
            end
         end else begin
            if (pos <= {6'd0, step}) begin
               npos = 10'd0;
               ndir = 1'b1;
            end else begin
               npos = pos - {6'd0, step};
            end
         end
      end
   end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite mover: X then Y through one step unit, committed atomically.
module sprite_motion_ctrl
   import sprite_motion_ctrl_pkg::*;
#(
   parameter int SCREEN_W   = SCREEN_W_DEF,
   parameter int SCREEN_H   = SCREEN_H_DEF,
   parameter int SPRITE_WID = SPRITE_WID_DEF,
   parameter int SPRITE_HGT = SPRITE_HGT_DEF,
   parameter int INIT_X     = 0,
   parameter int INIT_Y     = 0
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [8:0] RASTER_Y,
   input  logic       ENABLE,
   input  logic [3:0] STEP_X,
   input  logic [3:0] STEP_Y,
   input  logic [3:0] FRAME_DIV,
   input  logic       BLINK_EN,
   output logic [9:0] SPRITE_ORIGIN_OFFSET_X,
   output logic [8:0] SPRITE_ORIGIN_OFFSET_Y,
   output logic       VISIBLE,
   output logic       DIR_X,
   output logic       DIR_Y,
   output logic       BOUNCE
);

   localparam logic [9:0] LIM_X  = 10'(SCREEN_W - SPRITE_WID);
   localparam logic [9:0] LIM_Y  = 10'(SCREEN_H - SPRITE_HGT);
   localparam logic [9:0] X_INIT = 10'(INIT_X);
   localparam logic [8:0] Y_INIT = 9'(INIT_Y);

   state_t     state, state_nxt;
   logic       vbl, vbl_q, tick;
   logic [3:0] div_cnt;
   logic       div_hit;
   logic       go, sel_y, ld_x, ld_y, commit;
   logic [9:0] sh_x;
   logic [8:0] sh_y;
   logic       sh_dx, sh_dy;
   logic [9:0] su_pos, su_lim, su_npos;
   logic [3:0] su_step;
   logic       su_dir, su_ndir;

   assign vbl     = (RASTER_Y == 9'(SCREEN_H));
   assign tick    = vbl & ~vbl_q;
   assign div_hit = (div_cnt == FRAME_DIV);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (ENABLE) state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (!ENABLE)              state_nxt = ST_IDLE;
            else if (tick && div_hit) state_nxt = ST_CALC_X;
         end
         ST_CALC_X: state_nxt = ST_CALC_Y;
         ST_CALC_Y: state_nxt = ST_COMMIT;
         ST_COMMIT: state_nxt = ENABLE ? ST_WAIT : ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      go     = (state == ST_WAIT) && ENABLE && tick;
      ld_x   = (state == ST_CALC_X);
      ld_y   = (state == ST_CALC_Y);
      sel_y  = ld_y;
      commit = (state == ST_COMMIT);
   end

   assign su_pos  = sel_y ? {1'b0, SPRITE_ORIGIN_OFFSET_Y} : SPRITE_ORIGIN_OFFSET_X;
   assign su_dir  = sel_y ? DIR_Y  : DIR_X;
   assign su_step = sel_y ? STEP_Y : STEP_X;
   assign su_lim  = sel_y ? LIM_Y  : LIM_X;

   sprite_axis_step u_step (
      .pos  (su_pos),
      .dir  (su_dir),
      .step (su_step),
      .lim  (su_lim),
      .npos (su_npos),
      .ndir (su_ndir)
   );

   // vbl_q starts high so a reset released inside vblank does not fire a tick.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         vbl_q   <= 1'b1;
         div_cnt <= 4'd0;
      end else begin
         vbl_q <= vbl;
         if (go) div_cnt <= div_hit ? 4'd0 : div_cnt + 4'd1;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         sh_x  <= X_INIT;
         sh_dx <= 1'b1;
         sh_y  <= Y_INIT;
         sh_dy <= 1'b1;
      end else begin
         if (ld_x) begin
            sh_x  <= su_npos;
            sh_dx <= su_ndir;
         end
         if (ld_y) begin
            sh_y  <= su_npos[8:0];
            sh_dy <= su_ndir;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         SPRITE_ORIGIN_OFFSET_X <= X_INIT;
         SPRITE_ORIGIN_OFFSET_Y <= Y_INIT;
         VISIBLE                <= 1'b1;
         DIR_X                  <= 1'b1;
         DIR_Y                  <= 1'b1;
         BOUNCE                 <= 1'b0;
      end else begin
         BOUNCE <= 1'b0;
         if (commit) begin
            SPRITE_ORIGIN_OFFSET_X <= sh_x;
            SPRITE_ORIGIN_OFFSET_Y <= sh_y;
            DIR_X                  <= sh_dx;
            DIR_Y                  <= sh_dy;
            BOUNCE                 <= (sh_dx != DIR_X) || (sh_dy != DIR_Y);
            VISIBLE                <= VISIBLE ^ BLINK_EN;
         end
      end
   end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl with hand-computed positions.
module tb_sprite_motion_ctrl;

   logic       CLK = 1'b0;
   logic       RESET_N;
   logic [8:0] RASTER_Y;
   logic       ENABLE, BLINK_EN;
   logic [3:0] STEP_X, STEP_Y, FRAME_DIV;
   logic [9:0] SPRITE_ORIGIN_OFFSET_X;
   logic [8:0] SPRITE_ORIGIN_OFFSET_Y;
   logic       VISIBLE, DIR_X, DIR_Y, BOUNCE;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 CLK = ~CLK;

   sprite_motion_ctrl dut (
      .CLK                    (CLK),
      .RESET_N                (RESET_N),
      .RASTER_Y               (RASTER_Y),
      .ENABLE                 (ENABLE),
      .STEP_X                 (STEP_X),
      .STEP_Y                 (STEP_Y),
      .FRAME_DIV              (FRAME_DIV),
      .BLINK_EN               (BLINK_EN),
      .SPRITE_ORIGIN_OFFSET_X (SPRITE_ORIGIN_OFFSET_X),
      .SPRITE_ORIGIN_OFFSET_Y (SPRITE_ORIGIN_OFFSET_Y),
      .VISIBLE                (VISIBLE),
      .DIR_X                  (DIR_X),
      .DIR_Y                  (DIR_Y),
      .BOUNCE                 (BOUNCE)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
   endtask

   // One vblank line, then wait until 1 time unit after the would-be commit edge.
   task automatic frame(input logic [3:0] sx, input logic [3:0] sy);
      STEP_X = sx;
      STEP_Y = sy;
      @(posedge CLK); #1 RASTER_Y = 9'd480;
      @(posedge CLK); #1 RASTER_Y = 9'd0;
      @(posedge CLK);
      @(posedge CLK);
      @(posedge CLK); #1;
   endtask

   task automatic chk_pos(input string tag, input int x, input int y, input int dx, input int dy);
      chk({tag, ".x"},  32'(SPRITE_ORIGIN_OFFSET_X), 32'(x));
      chk({tag, ".y"},  32'(SPRITE_ORIGIN_OFFSET_Y), 32'(y));
      chk({tag, ".dx"}, 32'(DIR_X), 32'(dx));
      chk({tag, ".dy"}, 32'(DIR_Y), 32'(dy));
   endtask

   initial begin
      RESET_N = 1'b0; RASTER_Y = 9'd0; ENABLE = 1'b1; BLINK_EN = 1'b0;
      STEP_X = 4'd4; STEP_Y = 4'd2; FRAME_DIV = 4'd0;
      repeat (2) @(posedge CLK);
      #1;
      chk_pos("rst", 0, 0, 1, 1);
      chk("rst.vis", 32'(VISIBLE), 1);
      chk("rst.bounce", 32'(BOUNCE), 0);
      RESET_N = 1'b1;

      // Test 1: latency is exactly three edges after the tick edge
      @(posedge CLK); #1 RASTER_Y = 9'd480;
      @(posedge CLK); #1 RASTER_Y = 9'd0;
      chk("t1.e0", 32'(SPRITE_ORIGIN_OFFSET_X), 0);
      @(posedge CLK); #1 chk("t1.e1", 32'(SPRITE_ORIGIN_OFFSET_X), 0);
      @(posedge CLK); #1 chk("t1.e2", 32'(SPRITE_ORIGIN_OFFSET_X), 0);
      @(posedge CLK); #1;
      chk_pos("t1.e3", 4, 2, 1, 1);
      chk("t1.bounce", 32'(BOUNCE), 0);

      // Test 2: walk X to 596, then hit the right edge
      for (int i = 0; i < 39; i++) frame(4'd15, 4'd0);
      frame(4'd7, 4'd0);
      chk_pos("t2.pre", 596, 2, 1, 1);
      frame(4'd8, 4'd0);
      chk_pos("t2.hit", 600, 2, 0, 1);
      chk("t2.bounce", 32'(BOUNCE), 1);
      @(posedge CLK); #1 chk("t2.bounce_end", 32'(BOUNCE), 0);
      frame(4'd8, 4'd0);
      chk_pos("t2.next", 592, 2, 0, 1);
      chk("t2.bounce2", 32'(BOUNCE), 0);

      // Test 3: bring both axes near the origin heading down, then corner hit
      for (int i = 0; i < 39; i++) frame(4'd15, 4'd0);
      frame(4'd4, 4'd0);
      for (int i = 0; i < 30; i++) frame(4'd0, 4'd15);
      chk_pos("t3.ytop", 3, 440, 0, 0);
      for (int i = 0; i < 29; i++) frame(4'd0, 4'd15);
      frame(4'd0, 4'd3);
      chk_pos("t3.pre", 3, 2, 0, 0);
      frame(4'd3, 4'd5);
      chk_pos("t3.corner", 0, 0, 1, 1);
      chk("t3.bounce", 32'(BOUNCE), 1);
      @(posedge CLK); #1 chk("t3.bounce_end", 32'(BOUNCE), 0);

      // Test 4: FRAME_DIV=2 commits on vblanks 3, 6, 9; vblank 6 has zero steps
      FRAME_DIV = 4'd2;
      frame(4'd1, 4'd1); chk("t4.v1", 32'(SPRITE_ORIGIN_OFFSET_X), 0);
      frame(4'd1, 4'd1); chk("t4.v2", 32'(SPRITE_ORIGIN_OFFSET_X), 0);
      frame(4'd1, 4'd1); chk_pos("t4.v3", 1, 1, 1, 1);
      frame(4'd1, 4'd1); chk("t4.v4", 32'(SPRITE_ORIGIN_OFFSET_X), 1);
      frame(4'd1, 4'd1); chk("t4.v5", 32'(SPRITE_ORIGIN_OFFSET_X), 1);
      frame(4'd0, 4'd0); chk_pos("t4.v6", 1, 1, 1, 1);
      chk("t4.v6.bounce", 32'(BOUNCE), 0);
      frame(4'd1, 4'd1); chk("t4.v7", 32'(SPRITE_ORIGIN_OFFSET_X), 1);
      frame(4'd1, 4'd1); chk("t4.v8", 32'(SPRITE_ORIGIN_OFFSET_X), 1);
      frame(4'd1, 4'd1); chk_pos("t4.v9", 2, 2, 1, 1);

      // Test 5: blink on four commits, then drop ENABLE inside CALC_X
      FRAME_DIV = 4'd0;
      BLINK_EN  = 1'b1;
      frame(4'd0, 4'd0); chk("t5.vis1", 32'(VISIBLE), 0);
      frame(4'd0, 4'd0); chk("t5.vis2", 32'(VISIBLE), 1);
      frame(4'd0, 4'd0); chk("t5.vis3", 32'(VISIBLE), 0);
      frame(4'd0, 4'd0); chk("t5.vis4", 32'(VISIBLE), 1);
      BLINK_EN = 1'b0;
      STEP_X = 4'd2; STEP_Y = 4'd0;
      @(posedge CLK); #1 RASTER_Y = 9'd480;
      @(posedge CLK); #1 RASTER_Y = 9'd0;
      ENABLE = 1'b0;
      repeat (3) @(posedge CLK);
      #1 chk_pos("t5.drop", 4, 2, 1, 1);
      frame(4'd2, 4'd0);
      chk("t5.idle", 32'(SPRITE_ORIGIN_OFFSET_X), 4);
      frame(4'd2, 4'd0);
      chk("t5.idle2", 32'(SPRITE_ORIGIN_OFFSET_X), 4);

      // Test 6: reset released inside vblank, then reset during CALC_Y
      RESET_N = 1'b0; RASTER_Y = 9'd480; ENABLE = 1'b1;
      STEP_X = 4'd1; STEP_Y = 4'd1;
      repeat (2) @(posedge CLK);
      #1 RESET_N = 1'b1;
      repeat (4) @(posedge CLK);
      #1 chk_pos("t6.novbl", 0, 0, 1, 1);
      RASTER_Y = 9'd0;
      @(posedge CLK); #1;
      frame(4'd1, 4'd1);
      chk_pos("t6.run", 1, 1, 1, 1);
      @(posedge CLK); #1 RASTER_Y = 9'd480;
      @(posedge CLK); #1 RASTER_Y = 9'd0;
      @(posedge CLK); #1 RESET_N = 1'b0;
      #1;
      chk_pos("t6.rst", 0, 0, 1, 1);
      chk("t6.rst.vis", 32'(VISIBLE), 1);
      #2 RESET_N = 1'b1;
      repeat (4) @(posedge CLK);
      #1 chk_pos("t6.after", 0, 0, 1, 1);
      chk("t6.after.bounce", 32'(BOUNCE), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
